// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - decoupled instruction-fetch front end with redirect and J/JAL predecode
//
// Ports:
//   clk, rst_n                      clock (rising edge), asynchronous active-low reset
//   imem_req_valid/ready/addr       pipelined word requests to instruction memory
//   imem_rsp_valid/data             in-order response words (>= 1 cycle after acceptance)
//   redirect_valid/redirect_pc      downstream redirect; target bits [1:0] ignored
//   fetch_valid/ready/instr/pc      FIFO head handed to decode
//   fetch_count                     FIFO occupancy
module fetch_unit #(
  parameter int unsigned     XLEN           = 32,
  parameter int unsigned     DEPTH          = 4,
  parameter logic [XLEN-1:0] RESET_PC       = '0,
  parameter bit              PREDECODE_JUMP = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_rsp_valid,
  input  logic [31:0]              imem_rsp_data,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     fetch_valid,
  input  logic                     fetch_ready,
  output logic [31:0]              fetch_instr,
  output logic [XLEN-1:0]          fetch_pc,
  output logic [$clog2(DEPTH):0]   fetch_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned HW = XLEN - 28;
  localparam logic [CW:0] CAP = (CW+1)'(DEPTH);

  typedef enum logic {RUN, DRAIN} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   out_q, out_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [AW-1:0]   fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;

  logic [XLEN-1:0] tag_mem   [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [31:0]     instr_mem [DEPTH];

  logic            req_fire, rsp_take, pop, push, tag_push, is_jump;
  logic [XLEN-1:0] rsp_pc;
  logic [HW-1:0]   jump_hi;
  logic [CW:0]     occupancy;

  // Credit: buffered plus in-flight words never exceed DEPTH, so a response
  // always finds room in the FIFO. Gated by rst_n so nothing issues in reset.
  assign occupancy      = {1'b0, cnt_q} + {1'b0, out_q};
  assign imem_req_valid = rst_n && (state_q == RUN) && (occupancy < CAP);
  assign imem_req_addr  = pc_q;

  assign req_fire = imem_req_valid && imem_req_ready;
  // A response with nothing outstanding is stale (e.g. issued before reset).
  assign rsp_take = imem_rsp_valid && (out_q != '0);
  assign pop      = fetch_valid && fetch_ready;

  assign rsp_pc  = tag_mem[tag_rd_q];
  assign is_jump = PREDECODE_JUMP && (imem_rsp_data[31:27] == 5'b00001);
  // Upper bits of (P+4): carry into bit 28 only when P[27:2] is all ones.
  assign jump_hi = rsp_pc[XLEN-1:28] + HW'(&rsp_pc[27:2]);

  assign fetch_valid = (cnt_q != '0);
  assign fetch_instr = fetch_valid ? instr_mem[fifo_rd_q] : 32'h0;
  assign fetch_pc    = fetch_valid ? pc_mem[fifo_rd_q] : '0;
  assign fetch_count = cnt_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    out_d     = out_q + CW'(req_fire) - CW'(rsp_take);
    cnt_d     = cnt_q;
    fifo_wr_d = fifo_wr_q;
    fifo_rd_d = fifo_rd_q;
    tag_wr_d  = tag_wr_q;
    tag_rd_d  = tag_rd_q;
    push      = 1'b0;
    tag_push  = 1'b0;
    if (redirect_valid) begin
      // Everything younger than the redirect is wrong-path: flush the FIFO,
      // forget the tags, and let DRAIN swallow whatever is still in flight.
      pc_d      = redirect_pc & ~XLEN'(3);
      cnt_d     = '0;
      fifo_wr_d = '0;
      fifo_rd_d = '0;
      tag_wr_d  = '0;
      tag_rd_d  = '0;
      state_d   = (out_d != '0) ? DRAIN : RUN;
    end else begin
      if (state_q == RUN) begin
        push = rsp_take;
        if (req_fire) begin
          pc_d     = pc_q + XLEN'(4);
          tag_push = 1'b1;
          tag_wr_d = tag_wr_q + AW'(1);
        end
        if (rsp_take) tag_rd_d = tag_rd_q + AW'(1);
        if (rsp_take && is_jump) begin
          // The jump word itself is kept; only younger requests are dropped.
          pc_d = {jump_hi, imem_rsp_data[25:0], 2'b00};
          if (out_d != '0) begin
            state_d  = DRAIN;
            tag_wr_d = '0;
            tag_rd_d = '0;
          end
        end
      end else if (out_d == '0) begin
        state_d = RUN;
      end
      cnt_d     = cnt_q + CW'(push) - CW'(pop);
      fifo_wr_d = fifo_wr_q + AW'(push);
      fifo_rd_d = fifo_rd_q + AW'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      out_q     <= '0;
      cnt_q     <= '0;
      fifo_wr_q <= '0;
      fifo_rd_q <= '0;
      tag_wr_q  <= '0;
      tag_rd_q  <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      fifo_wr_q <= fifo_wr_d;
      fifo_rd_q <= fifo_rd_d;
      tag_wr_q  <= tag_wr_d;
      tag_rd_q  <= tag_rd_d;
    end
  end

  // Storage needs no reset: occupancy and pointers decide what is visible.
  always_ff @(posedge clk) begin
    if (tag_push) tag_mem[tag_wr_q] <= pc_q;
    if (push) begin
      pc_mem[fifo_wr_q]    <= rsp_pc;
      instr_mem[fifo_wr_q] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic [31:0] fetch_instr;
  logic [31:0] fetch_pc;
  logic [2:0]  fetch_count;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PREDECODE_JUMP(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_instr(fetch_instr),
    .fetch_pc(fetch_pc), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  typedef struct {
    bit          rst;
    bit          rdy;
    bit          rv;
    logic [31:0] rd;
    bit          redir;
    logic [31:0] rpc;
    bit          fr;
    bit          e_rv;
    logic [31:0] e_addr;
    bit          e_fv;
    logic [31:0] e_pc;
    logic [31:0] e_instr;
    int          e_cnt;
  } vec_t;

  function automatic vec_t mk(bit rst, bit rdy, bit rv, logic [31:0] rd, bit redir, logic [31:0] rpc,
                              bit fr, bit e_rv, logic [31:0] e_addr, bit e_fv, logic [31:0] e_pc,
                              logic [31:0] e_instr, int e_cnt);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rd = rd; v.redir = redir; v.rpc = rpc; v.fr = fr;
    v.e_rv = e_rv; v.e_addr = e_addr; v.e_fv = e_fv; v.e_pc = e_pc; v.e_instr = e_instr; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; fetch_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Instruction memory image: mostly non-jump words, roughly 1 in 8 a J/JAL to a low target.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [31:0] h;
    h = (a >> 2) * 32'h9E3779B1;
    h = h ^ (h >> 15);
    if (h[4:2] == 3'd0) return {5'b00001, h[5], 18'd0, h[13:6]};
    return {6'b100011, a[27:2]};
  endfunction

  function automatic logic [31:0] next_pc(input logic [31:0] p, input logic [31:0] instr);
    if (instr[31:27] == 5'b00001)
      return ((p + 32'd4) & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
    return p + 32'd4;
  endfunction

  vec_t vecs[$];

  task automatic run_table();
    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      if (v.rst) do_reset();
      else @(negedge clk);
      imem_req_ready = v.rdy; imem_rsp_valid = v.rv; imem_rsp_data = v.rd;
      redirect_valid = v.redir; redirect_pc = v.rpc; fetch_ready = v.fr;
      #1;
      chk($sformatf("v%0d_req_valid", i), imem_req_valid, v.e_rv);
      if (v.e_rv) chk($sformatf("v%0d_req_addr", i), imem_req_addr, v.e_addr);
      chk($sformatf("v%0d_fetch_valid", i), fetch_valid, v.e_fv);
      chk($sformatf("v%0d_count", i), fetch_count, v.e_cnt);
      if (v.e_fv) begin
        chk($sformatf("v%0d_fetch_pc", i), fetch_pc, v.e_pc);
        chk($sformatf("v%0d_fetch_instr", i), fetch_instr, v.e_instr);
      end
    end
  endtask

  task automatic run_async_reset();
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k != 0) @(negedge clk);
      imem_req_ready = 1'b1; fetch_ready = 1'b0;
      imem_rsp_valid = (k > 0);
      imem_rsp_data = 32'hB000_0000 | (32'(k) << 4);
    end
    @(negedge clk);
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0;
    #1;
    chk("pre_reset_count", fetch_count, 4);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_req_valid", imem_req_valid, 0);
    chk("async_req_addr", imem_req_addr, 0);
    chk("async_fetch_valid", fetch_valid, 0);
    chk("async_count", fetch_count, 0);
    chk("async_instr", fetch_instr, 0);
    chk("async_pc", fetch_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEAD_0000;
    #1;
    chk("post_reset_req_valid", imem_req_valid, 1);
    @(negedge clk);
    imem_rsp_valid = 1'b0;
    #1;
    chk("stale_rsp_dropped", fetch_count, 0);
  endtask

  task automatic run_random(input int n);
    logic [31:0] pend[$];
    logic [31:0] exp_pc, hold_pc, hold_instr, acc_addr, instr_m;
    bit          hold_v, acc, rvl;
    int          delivered, occ;
    exp_pc = 32'h0; hold_v = 1'b0; delivered = 0;
    hold_pc = 32'h0; hold_instr = 32'h0;
    do_reset();
    for (int c = 0; c < n; c++) begin
      if (c != 0) @(negedge clk);
      rvl = (pend.size() != 0) && ($urandom % 4 != 0);
      imem_rsp_valid = rvl;
      imem_rsp_data  = rvl ? mem_word(pend[0]) : $urandom;
      imem_req_ready = ($urandom % 4 != 0);
      fetch_ready    = ($urandom % 3 != 0);
      redirect_valid = ($urandom % 40 == 0);
      redirect_pc    = ($urandom % 8 == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom_range(0, 4095);
      #1;
      if (hold_v) begin
        chk("hold_valid", fetch_valid, 1);
        chk("hold_pc", fetch_pc, hold_pc);
        chk("hold_instr", fetch_instr, hold_instr);
      end
      occ = int'(fetch_count) + pend.size();
      if (occ > DEPTH) chk("credit_occupancy", occ, DEPTH);
      if (fetch_valid && fetch_ready) begin
        instr_m = mem_word(exp_pc);
        chk("rand_pc", fetch_pc, exp_pc);
        chk("rand_instr", fetch_instr, instr_m);
        exp_pc = next_pc(exp_pc, instr_m);
        delivered++;
      end
      if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
      hold_v = fetch_valid && !fetch_ready && !redirect_valid;
      hold_pc = fetch_pc; hold_instr = fetch_instr;
      acc = imem_req_valid && imem_req_ready;
      acc_addr = imem_req_addr;
      @(posedge clk);
      if (rvl) void'(pend.pop_front());
      if (acc) pend.push_back(acc_addr);
    end
    chk("rand_progress", (delivered >= 200) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    // Sequential stream, then back-pressure filling the FIFO to DEPTH.
    vecs.push_back(mk(1,1,0,32'h0,        0,32'h0,1, 1,32'h00,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,1,1,32'hA000_0000,0,32'h0,1, 1,32'h04,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,1,1,32'hA000_0004,0,32'h0,1, 1,32'h08,1,32'h0,32'hA000_0000,1));
    vecs.push_back(mk(0,1,1,32'hA000_0008,0,32'h0,0, 1,32'h0C,1,32'h4,32'hA000_0004,1));
    vecs.push_back(mk(0,1,1,32'hA000_000C,0,32'h0,0, 1,32'h10,1,32'h4,32'hA000_0004,2));
    vecs.push_back(mk(0,1,1,32'hA000_0010,0,32'h0,0, 0,32'h14,1,32'h4,32'hA000_0004,3));
    vecs.push_back(mk(0,1,0,32'h0,        0,32'h0,0, 0,32'h14,1,32'h4,32'hA000_0004,4));
    vecs.push_back(mk(0,1,0,32'h0,        0,32'h0,1, 0,32'h14,1,32'h4,32'hA000_0004,4));
    vecs.push_back(mk(0,0,0,32'h0,        0,32'h0,1, 1,32'h14,1,32'h8,32'hA000_0008,3));
    vecs.push_back(mk(0,0,0,32'h0,        0,32'h0,1, 1,32'h14,1,32'hC,32'hA000_000C,2));
    vecs.push_back(mk(0,0,0,32'h0,        0,32'h0,0, 1,32'h14,1,32'h10,32'hA000_0010,1));
    // Redirect with three requests in flight: all three dropped, restart at 0x100.
    vecs.push_back(mk(1,1,0,32'h0,        0,32'h0,  1, 1,32'h000,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,1,0,32'h0,        0,32'h0,  1, 1,32'h004,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,1,0,32'h0,        0,32'h0,  1, 1,32'h008,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,        1,32'h103,1, 1,32'h00C,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,1,1,32'hA000_0000,0,32'h0,  1, 0,32'h100,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,1,1,32'hA000_0004,0,32'h0,  1, 0,32'h100,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,1,1,32'hA000_0008,0,32'h0,  1, 0,32'h100,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,1,0,32'h0,        0,32'h0,  1, 1,32'h100,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,0,1,32'hA000_0100,0,32'h0,  1, 1,32'h104,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,        0,32'h0,  1, 1,32'h104,1,32'h100,32'hA000_0100,1));
    vecs.push_back(mk(0,0,0,32'h0,        0,32'h0,  1, 1,32'h104,0,32'h0,32'h0,0));
    // PC wrap, redirect colliding with a response and a pop, then a J predecode.
    vecs.push_back(mk(1,0,0,32'h0,        1,32'hFFFF_FFFC,0, 1,32'h0,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,1,0,32'h0,        0,32'h0,        0, 1,32'hFFFF_FFFC,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,1,1,32'h2000_0000,0,32'h0,        1, 1,32'h0,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,0,1,32'hA000_0000,1,32'h0040_0000,1, 1,32'h4,1,32'hFFFF_FFFC,32'h2000_0000,1));
    vecs.push_back(mk(0,1,0,32'h0,        0,32'h0,        0, 1,32'h0040_0000,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,1,1,32'h0800_0040,0,32'h0,        0, 1,32'h0040_0004,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,1,1,32'hA040_0004,0,32'h0,        1, 0,32'h100,1,32'h0040_0000,32'h0800_0040,1));
    vecs.push_back(mk(0,1,0,32'h0,        0,32'h0,        0, 1,32'h100,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,0,1,32'h1111_0100,0,32'h0,        0, 1,32'h104,0,32'h0,32'h0,0));
    vecs.push_back(mk(0,0,0,32'h0,        0,32'h0,        1, 1,32'h104,1,32'h100,32'h1111_0100,1));
    vecs.push_back(mk(0,0,0,32'h0,        0,32'h0,        1, 1,32'h104,0,32'h0,32'h0,0));

    run_table();
    run_async_reset();
    run_random(3000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
